// File: rtl/bird_pkg.sv
// Shared types and constants for the bird accumulator: FSM state encoding,
// default widths and the saturation limits of a default-width accumulator.
package bird_pkg;

  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/bird_accum_if.sv
// Burst control, sample input stream and result output stream of bird_accum.
// The master side is the burst source/sink, the slave side is the accumulator.
interface bird_accum_if #(
  parameter int WIDTH = bird_pkg::WIDTH,
  parameter int LEN_W = bird_pkg::LEN_W
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_of;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_of;
  logic [LEN_W-1:0] out_count;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, in_of, out_ready,
    input  in_ready, out_valid, out_data, out_of, out_count, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, in_of, out_ready,
    output in_ready, out_valid, out_data, out_of, out_count, busy
  );

endinterface

// File: rtl/bird_accum_sum.sv
// sum_bird: WIDTH-bit signed adder stage returning the wrapped sum and a
// signed-overflow flag (operands agree in sign, result does not).
module sum_bird #(
  parameter int WIDTH = bird_pkg::WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    of_sum
);

  assign sum    = a + b;
  assign of_sum = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/bird_accum.sv
// bird_accum: accumulates a burst of LEN signed samples into a saturating
// total with sticky overflow. Define BIRD_ACCUM_WRAP_EN for a wrapping total.
module bird_accum
  import bird_pkg::*;
#(
  parameter int WIDTH = bird_pkg::WIDTH,
  parameter int LEN_W = bird_pkg::LEN_W
) (
  input  logic         clk,
  input  logic         reset,
  bird_accum_if.slave  bus
);

  localparam logic signed [WIDTH-1:0] sat_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] sat_min = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state;
  logic signed [WIDTH-1:0] acc;
  logic        [LEN_W-1:0] remaining;
  logic        [LEN_W-1:0] count;
  logic                    sticky;

  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_of;
  logic        [LEN_W-1:0] out_count;
  logic                    busy;

  logic signed [WIDTH-1:0] sum;
  logic                    add_of;
  logic signed [WIDTH-1:0] acc_next;
  logic                    sticky_next;
  logic        [LEN_W-1:0] count_next;

  sum_bird #(.WIDTH(WIDTH)) u_sum (
    .a      (acc),
    .b      ($signed(bus.in_data)),
    .sum    (sum),
    .of_sum (add_of)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    acc_next = sum;
`ifndef BIRD_ACCUM_WRAP_EN
    // Clamp toward the sign of the incoming sample on overflow.
    if (add_of) begin
      acc_next = bus.in_data[WIDTH-1] ? sat_min : sat_max;
    end
`endif
    sticky_next = sticky | bus.in_of | add_of;
    count_next  = count + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      count     <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_of    <= 1'b0;
      out_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= '0;
            remaining <= bus.len;
            count     <= '0;
            sticky    <= 1'b0;
            busy      <= 1'b1;
            if (bus.len != '0) begin
              state <= ACCUM;
            end else begin
              // Empty burst: present a zero result straight away.
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= '0;
              out_of    <= 1'b0;
              out_count <= '0;
            end
          end
        end

        ACCUM: begin
          if (bus.in_valid) begin
            acc       <= acc_next;
            sticky    <= sticky_next;
            count     <= count_next;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= acc_next;
              out_of    <= sticky_next;
              out_count <= count_next;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_of    <= 1'b0;
            out_count <= '0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_of    = out_of;
  assign bus.out_count = out_count;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_bird_accum.sv
// Directed testbench for bird_accum: hand-computed bursts covering plain sums,
// saturation, sticky flags, empty bursts, backpressure, stalls and reset.
module tb_bird_accum;
  import bird_pkg::*;

  localparam int W  = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  bird_accum_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  bird_accum #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_burst(input int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l[LW-1:0];
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input int d, input logic of);
    int n;
    n = 0;
    bus.in_data  = d[W-1:0];
    bus.in_of    = of;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("in_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_of    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic collect(input string tag, input int d, input int of, input int cnt);
    check({tag, " out_valid"}, int'(bus.out_valid), 1);
    check({tag, " out_data"},  int'($signed(bus.out_data)), d);
    check({tag, " out_of"},    int'(bus.out_of), of);
    check({tag, " out_count"}, int'(bus.out_count), cnt);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " valid drop"}, int'(bus.out_valid), 0);
    check({tag, " busy drop"},  int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_pos;
    int exp_neg;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_of     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset in_ready",  int'(bus.in_ready), 0);
    check("reset busy",      int'(bus.busy), 0);
    check("reset out_data",  int'($signed(bus.out_data)), 0);
    #11;
    reset = 1'b0;
    idle(1);

    // Basic sum with 1-cycle result latency
    start_burst(2);
    check("basic busy", int'(bus.busy), 1);
    check("basic in_ready", int'(bus.in_ready), 1);
    send(32767, 1'b0);
    check("basic mid valid", int'(bus.out_valid), 0);
    send(-64, 1'b0);
    collect("basic", 32703, 0, 2);

    // Positive overflow: 8192 + 32767
`ifdef BIRD_ACCUM_WRAP_EN
    exp_pos = -24577;
    exp_neg = -32513;
`else
    exp_pos = int'(SAT_MAX);
    exp_neg = -32512;
`endif
    start_burst(2);
    send(8192, 1'b0);
    send(32767, 1'b0);
    collect("pos sat", exp_pos, 1, 2);

    // Negative overflow then recovery: -32768, -1, 256
    start_burst(3);
    send(-32768, 1'b0);
    send(-1, 1'b0);
    send(256, 1'b0);
    collect("neg sat", exp_neg, 1, 3);

    // Upstream overflow flag alone sets the sticky bit
    start_burst(1);
    send(16, 1'b1);
    collect("upstream of", 16, 1, 1);

    // Empty burst, then backpressure with ignored start pulses
    start_burst(0);
    check("zero valid", int'(bus.out_valid), 1);
    check("zero in_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      bus.start = ~i[0];
      bus.len   = 8'd5;
      @(posedge clk);
      #1;
      check("bp valid", int'(bus.out_valid), 1);
      check("bp data",  int'($signed(bus.out_data)), 0);
      check("bp count", int'(bus.out_count), 0);
    end
    bus.start = 1'b0;
    collect("zero", 0, 0, 0);
    idle(2);
    check("bp start ignored busy", int'(bus.busy), 0);
    check("bp start ignored valid", int'(bus.out_valid), 0);

    // Stalled burst interrupted by reset
    start_burst(4);
    send(-2048, 1'b0);
    idle(2);
    send(-4096, 1'b0);
    check("stall acc", int'($signed(dut.acc)), -6144);
    check("stall busy", int'(bus.busy), 1);
    check("stall valid", int'(bus.out_valid), 0);
    #3;
    reset = 1'b1;
    #1;
    check("async reset busy",     int'(bus.busy), 0);
    check("async reset in_ready", int'(bus.in_ready), 0);
    check("async reset valid",    int'(bus.out_valid), 0);
    check("async reset data",     int'($signed(bus.out_data)), 0);
    check("async reset count",    int'(bus.out_count), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("post reset idle valid", int'(bus.out_valid), 0);

    // Fresh burst after reset
    start_burst(1);
    send(4, 1'b0);
    collect("post reset", 4, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
